// File: rtl/control_unit_fsm_pkg.sv
// Shared types for the multicycle RV64I control unit: FSM states,
// datapath select codes, splice codes and opcode/funct3 encodings.
package control_unit_fsm_pkg;

    localparam int MEM_TIMEOUT_DEF = 15;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_BU = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_WB_ALU,
        S_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR,
        S_NEXT_PC, S_BRANCH, S_JAL, S_JALR, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_SUM, ALU_SUB, ALU_SLL, ALU_SRL,
        ALU_SRA, ALU_XOR, ALU_AND, ALU_LESS
    } ops_alu;

    typedef enum logic [1:0] {
        _ALA_PC, _ALA_REG_A, _ALA_ZERO
    } alu_src_a_e;

    typedef enum logic [1:0] {
        _ALB_REG_B, _ALB_IMM, _ALB_IMM2, _ALB_CONST4
    } alu_src_b_e;

    typedef enum logic {
        _PC_ALU_OUT, _PC_ALU_REG
    } pc_source_e;

    typedef enum logic [1:0] {
        _FW_ALU_OUT, _FW_MEM_OUT, _FW_PC_4
    } file_write_e;

    typedef enum logic [1:0] {
        SPL_LD, SPL_LW, SPL_LH, SPL_LBU
    } splice_load;

    typedef enum logic [1:0] {
        SPS_SD, SPS_SW, SPS_SH, SPS_SB
    } splice_store;

    typedef enum logic [3:0] {
        CL_ALU_R, CL_ALU_I, CL_LUI, CL_AUIPC, CL_LOAD,
        CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_BAD
    } instr_class_e;

    typedef struct packed {
        logic   bad;
        ops_alu op;
    } alu_map_t;

    // OR/ORI and SLT(I)U have no matching ALU operation.
    function automatic alu_map_t alu_map(
        input logic [2:0] f3,
        input logic       alt,
        input logic       r_type
    );
        alu_map_t m;
        m.bad = 1'b0;
        m.op  = ALU_SUM;
        unique case (f3)
            F3_ADD:  m.op = (r_type && alt) ? ALU_SUB : ALU_SUM;
            F3_SLL:  m.op = ALU_SLL;
            F3_SLT:  m.op = ALU_LESS;
            F3_XOR:  m.op = ALU_XOR;
            F3_SR:   m.op = alt ? ALU_SRA : ALU_SRL;
            F3_AND:  m.op = ALU_AND;
            default: m.bad = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/control_unit_fsm_instr_class_decoder.sv
// Combinational instruction classifier: opcode/funct fields to class,
// ALU operation, load/store splice codes and an illegal flag.
module control_unit_fsm_instr_class_decoder
    import control_unit_fsm_pkg::*;
(
    input  logic [6:0]   opcode_i,
    input  logic [2:0]   funct3_i,
    input  logic         alt_i,
    output instr_class_e cls_o,
    output ops_alu       alu_op_o,
    output splice_load   load_o,
    output splice_store  store_o,
    output logic         bad_o
);

    alu_map_t m;

    always_comb begin
        cls_o    = CL_BAD;
        alu_op_o = ALU_SUM;
        load_o   = SPL_LD;
        store_o  = SPS_SD;
        bad_o    = 1'b1;
        m = alu_map(funct3_i, alt_i, opcode_i == OPC_OP);
        unique case (opcode_i)
            OPC_OP: begin
                cls_o    = CL_ALU_R;
                alu_op_o = m.op;
                bad_o    = m.bad;
            end
            OPC_OP_IMM: begin
                cls_o    = CL_ALU_I;
                alu_op_o = m.op;
                bad_o    = m.bad;
            end
            OPC_LUI: begin
                cls_o = CL_LUI;
                bad_o = 1'b0;
            end
            OPC_AUIPC: begin
                cls_o = CL_AUIPC;
                bad_o = 1'b0;
            end
            OPC_JAL: begin
                cls_o = CL_JAL;
                bad_o = 1'b0;
            end
            OPC_JALR: begin
                cls_o = CL_JALR;
                bad_o = 1'b0;
            end
            OPC_LOAD: begin
                cls_o = CL_LOAD;
                bad_o = 1'b0;
                unique case (funct3_i)
                    F3_D:    load_o = SPL_LD;
                    F3_W:    load_o = SPL_LW;
                    F3_H:    load_o = SPL_LH;
                    F3_BU:   load_o = SPL_LBU;
                    default: bad_o  = 1'b1;
                endcase
            end
            OPC_STORE: begin
                cls_o = CL_STORE;
                bad_o = 1'b0;
                unique case (funct3_i)
                    F3_D:    store_o = SPS_SD;
                    F3_W:    store_o = SPS_SW;
                    F3_H:    store_o = SPS_SH;
                    F3_B:    store_o = SPS_SB;
                    default: bad_o   = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                cls_o = CL_BRANCH;
                bad_o = 1'b0;
                unique case (funct3_i)
                    F3_BEQ, F3_BNE: alu_op_o = ALU_SUB;
                    F3_BLT, F3_BGE: alu_op_o = ALU_LESS;
                    default:        bad_o    = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit_fsm.sv
// Multicycle RV64I control FSM: sequences fetch/decode/execute/memory/
// writeback, drives datapath enables and handshakes with memory.
module control_unit_fsm
    import control_unit_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        mdr_write,
    output logic        alu_reg_write,
    output logic        pc_write,
    output logic        reg_write,
    output ops_alu      alu_op,
    output alu_src_a_e  alu_src_a,
    output alu_src_b_e  alu_src_b,
    output pc_source_e  pc_source,
    output file_write_e file_write,
    output splice_load  load_sel,
    output splice_store store_sel,
    output logic        halted,
    output logic        err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    instr_class_e  cls;
    ops_alu        dec_op;
    splice_load    dec_ld;
    splice_store   dec_st;
    logic          dec_bad;
    logic          taken;
    logic          unused_instr;

    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    control_unit_fsm_instr_class_decoder u_dec (
        .opcode_i (instr[6:0]),
        .funct3_i (instr[14:12]),
        .alt_i    (instr[30]),
        .cls_o    (cls),
        .alu_op_o (dec_op),
        .load_o   (dec_ld),
        .store_o  (dec_st),
        .bad_o    (dec_bad)
    );

    always_comb begin
        case (instr[14:12])
            F3_BEQ:  taken = alu_zero;
            F3_BNE:  taken = !alu_zero;
            F3_BLT:  taken = alu_lt;
            default: taken = !alu_lt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        err_d         = err_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        alu_reg_write = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_op        = ALU_SUM;
        alu_src_a     = _ALA_PC;
        alu_src_b     = _ALB_REG_B;
        pc_source     = _PC_ALU_OUT;
        file_write    = _FW_ALU_OUT;
        load_sel      = SPL_LD;
        store_sel     = SPS_SD;
        halted        = 1'b0;
        err           = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    if (mem_ready) state_d = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_b     = _ALB_IMM2;
                    alu_reg_write = 1'b1;
                    unique case (cls)
                        CL_ALU_R, CL_ALU_I,
                        CL_LUI, CL_AUIPC:    state_d = S_EXEC;
                        CL_LOAD, CL_STORE:   state_d = S_ADDR;
                        CL_BRANCH:           state_d = S_BRANCH;
                        CL_JAL:              state_d = S_JAL;
                        CL_JALR:             state_d = S_JALR;
                        default:             state_d = S_HALT;
                    endcase
                end
                S_EXEC: begin
                    if (dec_bad) begin
                        state_d = S_HALT;
                    end else begin
                        alu_reg_write = 1'b1;
                        alu_op        = dec_op;
                        alu_src_a     = _ALA_REG_A;
                        alu_src_b     = _ALB_IMM;
                        state_d       = S_WB_ALU;
                        case (cls)
                            CL_ALU_R: alu_src_b = _ALB_REG_B;
                            CL_LUI:   alu_src_a = _ALA_ZERO;
                            CL_AUIPC: alu_src_a = _ALA_PC;
                            default:  ;
                        endcase
                    end
                end
                S_WB_ALU, S_WB_MEM, S_NEXT_PC: begin
                    reg_write  = state_q != S_NEXT_PC;
                    file_write = (state_q == S_WB_MEM) ?
                                 _FW_MEM_OUT : _FW_ALU_OUT;
                    alu_src_b  = _ALB_CONST4;
                    pc_write   = 1'b1;
                    state_d    = S_FETCH;
                end
                S_ADDR: begin
                    if (dec_bad) begin
                        state_d = S_HALT;
                    end else begin
                        alu_src_a     = _ALA_REG_A;
                        alu_src_b     = _ALB_IMM;
                        alu_reg_write = 1'b1;
                        state_d       = (cls == CL_LOAD) ?
                                        S_MEM_RD : S_MEM_WR;
                    end
                end
                S_MEM_RD: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    load_sel  = dec_ld;
                    mdr_write = mem_ready;
                    if (mem_ready) state_d = S_WB_MEM;
                end
                S_MEM_WR: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    iord      = 1'b1;
                    store_sel = dec_st;
                    if (mem_ready) state_d = S_NEXT_PC;
                end
                S_BRANCH: begin
                    if (dec_bad) begin
                        state_d = S_HALT;
                    end else begin
                        alu_op    = dec_op;
                        alu_src_a = _ALA_REG_A;
                        alu_src_b = _ALB_REG_B;
                        pc_write  = taken;
                        pc_source = taken ? _PC_ALU_REG : _PC_ALU_OUT;
                        state_d   = taken ? S_FETCH : S_NEXT_PC;
                    end
                end
                S_JAL: begin
                    reg_write  = 1'b1;
                    file_write = _FW_PC_4;
                    pc_write   = 1'b1;
                    pc_source  = _PC_ALU_REG;
                    state_d    = S_FETCH;
                end
                S_JALR: begin
                    alu_src_a  = _ALA_REG_A;
                    alu_src_b  = _ALB_IMM;
                    reg_write  = 1'b1;
                    file_write = _FW_PC_4;
                    pc_write   = 1'b1;
                    state_d    = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                    err    = err_q;
                end
                default: state_d = S_HALT;
            endcase
            // Stalled memory access: bounded wait, then halt with error.
            if (mem_req && !mem_ready) begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed-vector bench for control_unit_fsm: walks each instruction
// class through the FSM and checks enables and selects per cycle.
module tb_control_unit_fsm;
    import control_unit_fsm_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        alu_zero;
    logic        alu_lt;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_write, mdr_write;
    logic        alu_reg_write, pc_write, reg_write;
    logic        halted, err;
    ops_alu      alu_op;
    alu_src_a_e  alu_src_a;
    alu_src_b_e  alu_src_b;
    pc_source_e  pc_source;
    file_write_e file_write;
    splice_load  load_sel;
    splice_store store_sel;

    int n_vec;
    int n_bad;

    localparam logic [9:0] REQ  = 10'h200;
    localparam logic [9:0] WE   = 10'h100;
    localparam logic [9:0] IORD = 10'h080;
    localparam logic [9:0] IRW  = 10'h040;
    localparam logic [9:0] MDRW = 10'h020;
    localparam logic [9:0] ARW  = 10'h010;
    localparam logic [9:0] PCW  = 10'h008;
    localparam logic [9:0] RW   = 10'h004;
    localparam logic [9:0] HLT  = 10'h002;
    localparam logic [9:0] ERR  = 10'h001;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LD   = 32'h0080B283;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JALR = 32'h000280E7;
    localparam logic [31:0] I_OR   = 32'h0020E1B3;
    localparam logic [31:0] I_7F   = 32'h0000007F;

    logic [9:0] ctl;
    assign ctl = {mem_req, mem_we, iord, ir_write, mdr_write,
                  alu_reg_write, pc_write, reg_write, halted, err};

    control_unit_fsm #(.MEM_TIMEOUT(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr         (instr),
        .alu_zero      (alu_zero),
        .alu_lt        (alu_lt),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .mdr_write     (mdr_write),
        .alu_reg_write (alu_reg_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .file_write    (file_write),
        .load_sel      (load_sel),
        .store_sel     (store_sel),
        .halted        (halted),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input ops_alu o,
                                       input alu_src_a_e a,
                                       input alu_src_b_e b,
                                       input pc_source_e p,
                                       input file_write_e f);
        return 32'({o, a, b, p, f});
    endfunction

    function automatic logic [31:0] sel();
        return pk(alu_op, alu_src_a, alu_src_b, pc_source, file_write);
    endfunction

    task automatic cyc(input string tag, input logic rdy,
                       input logic [9:0] exp);
        mem_ready = rdy;
        #1;
        check(tag, 32'(ctl), 32'(exp));
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        cyc(tag, 1'b1, '0);
        nxt();
        reset = 1'b0;
    endtask

    task automatic fetch_dec(input string tag, input logic [31:0] ins);
        instr = ins;
        cyc({tag, ".fetch"}, 1'b1, REQ | IRW);
        nxt();
        cyc({tag, ".dec"}, 1'b1, ARW);
        check({tag, ".dec.sel"}, sel(),
              pk(ALU_SUM, _ALA_PC, _ALB_IMM2, _PC_ALU_OUT, _FW_ALU_OUT));
        nxt();
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        instr     = '0;
        alu_zero  = 1'b0;
        alu_lt    = 1'b0;
        mem_ready = 1'b1;

        cyc("rst.ctl", 1'b1, '0);
        check("rst.sel", sel(), '0);
        nxt();
        reset = 1'b0;

        fetch_dec("add", I_ADD);
        cyc("add.exec", 1'b1, ARW);
        check("add.exec.sel", sel(),
              pk(ALU_SUM, _ALA_REG_A, _ALB_REG_B, _PC_ALU_OUT, _FW_ALU_OUT));
        nxt();
        cyc("add.wb", 1'b1, RW | PCW);
        check("add.wb.sel", sel(),
              pk(ALU_SUM, _ALA_PC, _ALB_CONST4, _PC_ALU_OUT, _FW_ALU_OUT));
        nxt();

        fetch_dec("ld", I_LD);
        cyc("ld.addr", 1'b1, ARW);
        check("ld.addr.sel", sel(),
              pk(ALU_SUM, _ALA_REG_A, _ALB_IMM, _PC_ALU_OUT, _FW_ALU_OUT));
        nxt();
        for (int i = 0; i < 3; i++) begin
            cyc("ld.wait", 1'b0, REQ | IORD);
            check("ld.lsel", 32'(load_sel), 32'(SPL_LD));
            nxt();
        end
        cyc("ld.done", 1'b1, REQ | IORD | MDRW);
        nxt();
        cyc("ld.wb", 1'b1, RW | PCW);
        check("ld.wb.sel", sel(),
              pk(ALU_SUM, _ALA_PC, _ALB_CONST4, _PC_ALU_OUT, _FW_MEM_OUT));
        nxt();

        fetch_dec("sw", I_SW);
        cyc("sw.addr", 1'b1, ARW);
        nxt();
        cyc("sw.mem", 1'b1, REQ | WE | IORD);
        check("sw.ssel", 32'(store_sel), 32'(SPS_SW));
        nxt();
        cyc("sw.npc", 1'b1, PCW);
        nxt();

        fetch_dec("mid", I_LD);
        cyc("mid.addr", 1'b1, ARW);
        nxt();
        cyc("mid.wait", 1'b0, REQ | IORD);
        nxt();
        reset = 1'b1;
        cyc("mid.rst", 1'b0, '0);
        nxt();
        reset = 1'b0;

        alu_zero = 1'b1;
        fetch_dec("beq1", I_BEQ);
        cyc("beq1.br", 1'b1, PCW);
        check("beq1.sel", sel(),
              pk(ALU_SUB, _ALA_REG_A, _ALB_REG_B, _PC_ALU_REG, _FW_ALU_OUT));
        nxt();

        alu_zero = 1'b0;
        fetch_dec("beq0", I_BEQ);
        cyc("beq0.br", 1'b1, '0);
        nxt();
        cyc("beq0.npc", 1'b1, PCW);
        check("beq0.npc.sel", sel(),
              pk(ALU_SUM, _ALA_PC, _ALB_CONST4, _PC_ALU_OUT, _FW_ALU_OUT));
        nxt();

        fetch_dec("jalr", I_JALR);
        cyc("jalr.x", 1'b1, RW | PCW);
        check("jalr.sel", sel(),
              pk(ALU_SUM, _ALA_REG_A, _ALB_IMM, _PC_ALU_OUT, _FW_PC_4));
        nxt();

        fetch_dec("or", I_OR);
        cyc("or.exec", 1'b1, '0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            cyc("or.halt", 1'(i), HLT);
            nxt();
        end
        do_reset("or.rst");

        fetch_dec("op7f", I_7F);
        cyc("op7f.halt", 1'b1, HLT);
        nxt();
        cyc("op7f.hold", 1'b0, HLT);
        nxt();
        do_reset("op7f.rst");

        instr = I_ADD;
        for (int i = 0; i < 15; i++) begin
            cyc("to.wait", 1'b0, REQ);
            nxt();
        end
        cyc("to.halt", 1'b0, HLT | ERR);
        nxt();
        cyc("to.hold", 1'b1, HLT | ERR);
        nxt();
        do_reset("to.rst");
        cyc("to.fetch", 1'b1, REQ | IRW);
        nxt();
        cyc("to.dec", 1'b1, ARW);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
